// File: rtl/hsv_convert_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : hsv_convert_pipe_if
// Description : Pixel bus for the RGB-to-HSV converter. Carries the input
//               pixel (valid, R, G, B, tag) and the converted output pixel
//               (valid, H, S, V, tag).
//   master : pixel source / result sink (drives in_*, observes out_*)
//   slave  : the converter (observes in_*, drives out_*)
// Parameters  : CW - component width, UW - sideband tag width
// Revision    : 1.0 - initial release
// ============================================================================
interface hsv_convert_pipe_if #(
  parameter int CW = 8,
  parameter int UW = 2
);
  logic          in_valid;
  logic [CW-1:0] in_r;
  logic [CW-1:0] in_g;
  logic [CW-1:0] in_b;
  logic [UW-1:0] in_user;

  logic          out_valid;
  logic [CW-1:0] out_h;
  logic [CW-1:0] out_s;
  logic [CW-1:0] out_v;
  logic [UW-1:0] out_user;

  modport master (
    output in_valid, in_r, in_g, in_b, in_user,
    input  out_valid, out_h, out_s, out_v, out_user
  );

  modport slave (
    input  in_valid, in_r, in_g, in_b, in_user,
    output out_valid, out_h, out_s, out_v, out_user
  );
endinterface
`default_nettype wire

// File: rtl/hsv_convert_pipe.sv
`default_nettype none
// ============================================================================
// Module      : hsv_convert_pipe
// Description : Fully pipelined RGB-to-HSV converter, one pixel per clock,
//               fixed latency of CW+4 cycles. Saturation and hue quotients
//               come from two CW-stage restoring dividers running in
//               parallel. The sideband tag travels with its pixel.
// Ports       : clock - rising-edge system clock
//               reset - synchronous, active-high; clears all valid bits and
//                       the output registers
//               bus   - hsv_convert_pipe_if.slave: in_valid/in_r/in_g/in_b/
//                       in_user in, out_valid/out_h/out_s/out_v/out_user out
// Parameters  : CW - component width (6..12), UW - tag width
// Revision    : 1.0 - initial release
// ============================================================================
module hsv_convert_pipe #(
  parameter int CW = 8,
  parameter int UW = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  hsv_convert_pipe_if.slave    bus
);

  localparam int C_MAXV = (1 << CW) - 1;
  localparam int C_W2   = 2 * CW;       // numerator width
  localparam int C_DW   = CW + 3;       // denominator width, holds 6*MAXV
  localparam int C_RW   = 2 * CW + 3;   // partial remainder / trial width

  localparam logic [CW-1:0] C_OFF_G = CW'(C_MAXV / 3);
  localparam logic [CW-1:0] C_OFF_B = CW'((2 * C_MAXV) / 3);

  localparam logic [1:0] C_SEL_R = 2'd0;
  localparam logic [1:0] C_SEL_G = 2'd1;
  localparam logic [1:0] C_SEL_B = 2'd2;

  // --------------------------------------------------------------------------
  // Stage 1: input registers
  // --------------------------------------------------------------------------
  logic          r_s1_valid;
  logic [CW-1:0] r_s1_r;
  logic [CW-1:0] r_s1_g;
  logic [CW-1:0] r_s1_b;
  logic [UW-1:0] r_s1_user;

  always_ff @(posedge clock) begin
    r_s1_r    <= bus.in_r;
    r_s1_g    <= bus.in_g;
    r_s1_b    <= bus.in_b;
    r_s1_user <= bus.in_user;
  end

  // --------------------------------------------------------------------------
  // Stage 2: max / min / max selector (ties resolve R, then G, then B)
  // --------------------------------------------------------------------------
  logic [CW-1:0] w_s2_max;
  logic [CW-1:0] w_s2_min;
  logic [1:0]    w_s2_sel;

  always_comb begin
    w_s2_sel = C_SEL_R;
    w_s2_max = r_s1_r;
    if (!((r_s1_r >= r_s1_g) && (r_s1_r >= r_s1_b))) begin
      if (r_s1_g >= r_s1_b) begin
        w_s2_sel = C_SEL_G;
        w_s2_max = r_s1_g;
      end else begin
        w_s2_sel = C_SEL_B;
        w_s2_max = r_s1_b;
      end
    end
    w_s2_min = (r_s1_r <= r_s1_g) ? r_s1_r : r_s1_g;
    if (r_s1_b < w_s2_min) begin
      w_s2_min = r_s1_b;
    end
  end

  logic          r_s2_valid;
  logic [CW-1:0] r_s2_r;
  logic [CW-1:0] r_s2_g;
  logic [CW-1:0] r_s2_b;
  logic [CW-1:0] r_s2_max;
  logic [CW-1:0] r_s2_min;
  logic [1:0]    r_s2_sel;
  logic [UW-1:0] r_s2_user;

  always_ff @(posedge clock) begin
    r_s2_r    <= r_s1_r;
    r_s2_g    <= r_s1_g;
    r_s2_b    <= r_s1_b;
    r_s2_max  <= w_s2_max;
    r_s2_min  <= w_s2_min;
    r_s2_sel  <= w_s2_sel;
    r_s2_user <= r_s1_user;
  end

  // --------------------------------------------------------------------------
  // Stage 3: numerators, denominators and hue context
  // --------------------------------------------------------------------------
  logic [CW-1:0]   w_delta;
  logic [CW-1:0]   w_h_a;
  logic [CW-1:0]   w_h_b;
  logic [CW-1:0]   w_h_abs;
  logic            w_h_neg;
  logic [CW-1:0]   w_h_off;
  logic [C_W2-1:0] w_s_num;
  logic [C_W2-1:0] w_h_num;
  logic [C_DW-1:0] w_s_den;
  logic [C_DW-1:0] w_h_den;

  always_comb begin
    w_delta = r_s2_max - r_s2_min;
    // Hue difference operands: R uses g-b, G uses b-r, B uses r-g
    w_h_a   = r_s2_g;
    w_h_b   = r_s2_b;
    w_h_off = '0;
    case (r_s2_sel)
      C_SEL_G: begin
        w_h_a   = r_s2_b;
        w_h_b   = r_s2_r;
        w_h_off = C_OFF_G;
      end
      C_SEL_B: begin
        w_h_a   = r_s2_r;
        w_h_b   = r_s2_g;
        w_h_off = C_OFF_B;
      end
      default: ;
    endcase
    w_h_neg = (w_h_a < w_h_b);
    w_h_abs = w_h_neg ? (w_h_b - w_h_a) : (w_h_a - w_h_b);

    w_s_num = C_W2'(w_delta) * C_W2'(C_MAXV);
    w_h_num = C_W2'(w_h_abs) * C_W2'(C_MAXV);
    // A zero divisor only occurs with a zero numerator (black or grey);
    // substituting a non-zero divisor yields the required quotient of 0.
    w_s_den = (r_s2_max == '0) ? C_DW'(1) : C_DW'(r_s2_max);
    w_h_den = (w_delta == '0) ? C_DW'(6) : (C_DW'(w_delta) * C_DW'(6));
  end

  // --------------------------------------------------------------------------
  // Stages 4..CW+3: restoring dividers. Index 0 of each array is the stage-3
  // register; index k+1 is the register of stage 4+k. The remainder and
  // divisor are not needed after the last quotient bit, so those arrays stop
  // one stage short.
  // --------------------------------------------------------------------------
  logic [C_RW-1:0] r_p_s_rem [0:CW-1];
  logic [C_RW-1:0] r_p_h_rem [0:CW-1];
  logic [C_DW-1:0] r_p_s_den [0:CW-1];
  logic [C_DW-1:0] r_p_h_den [0:CW-1];
  logic [CW-1:0]   r_p_s_q   [0:CW];
  logic [CW-1:0]   r_p_h_q   [0:CW];
  logic [CW-1:0]   r_p_v     [0:CW];
  logic [CW-1:0]   r_p_off   [0:CW];
  logic [UW-1:0]   r_p_user  [0:CW];
  logic [CW:0]     r_p_neg;
  logic [CW:0]     r_p_vld;

  logic [C_RW-1:0] w_s_trial  [0:CW-1];
  logic [C_RW-1:0] w_h_trial  [0:CW-1];
  logic [CW-1:0]   w_s_ge;
  logic [CW-1:0]   w_h_ge;
  logic [CW-1:0]   w_s_q_nx   [0:CW-1];
  logic [CW-1:0]   w_h_q_nx   [0:CW-1];
  logic [C_RW-1:0] w_s_rem_nx [0:CW-2];
  logic [C_RW-1:0] w_h_rem_nx [0:CW-2];

  always_comb begin
    for (int k = 0; k < CW; k++) begin
      // Step k decides quotient bit CW-1-k (MSB first)
      w_s_trial[k] = C_RW'(r_p_s_den[k]) << (CW - 1 - k);
      w_h_trial[k] = C_RW'(r_p_h_den[k]) << (CW - 1 - k);
      w_s_ge[k]    = (r_p_s_rem[k] >= w_s_trial[k]);
      w_h_ge[k]    = (r_p_h_rem[k] >= w_h_trial[k]);
      w_s_q_nx[k]  = r_p_s_q[k] | (CW'(w_s_ge[k]) << (CW - 1 - k));
      w_h_q_nx[k]  = r_p_h_q[k] | (CW'(w_h_ge[k]) << (CW - 1 - k));
    end
    for (int k = 0; k < CW - 1; k++) begin
      w_s_rem_nx[k] = w_s_ge[k] ? (r_p_s_rem[k] - w_s_trial[k]) : r_p_s_rem[k];
      w_h_rem_nx[k] = w_h_ge[k] ? (r_p_h_rem[k] - w_h_trial[k]) : r_p_h_rem[k];
    end
  end

  // Data path registers advance every cycle; only valid bits are reset.
  always_ff @(posedge clock) begin
    r_p_s_rem[0] <= C_RW'(w_s_num);
    r_p_h_rem[0] <= C_RW'(w_h_num);
    r_p_s_den[0] <= w_s_den;
    r_p_h_den[0] <= w_h_den;
    r_p_s_q[0]   <= '0;
    r_p_h_q[0]   <= '0;
    r_p_v[0]     <= r_s2_max;
    r_p_off[0]   <= w_h_off;
    r_p_neg[0]   <= w_h_neg;
    r_p_user[0]  <= r_s2_user;
    for (int k = 0; k < CW; k++) begin
      r_p_s_q[k+1]  <= w_s_q_nx[k];
      r_p_h_q[k+1]  <= w_h_q_nx[k];
      r_p_v[k+1]    <= r_p_v[k];
      r_p_off[k+1]  <= r_p_off[k];
      r_p_neg[k+1]  <= r_p_neg[k];
      r_p_user[k+1] <= r_p_user[k];
    end
    for (int k = 0; k < CW - 1; k++) begin
      r_p_s_rem[k+1] <= w_s_rem_nx[k];
      r_p_h_rem[k+1] <= w_h_rem_nx[k];
      r_p_s_den[k+1] <= r_p_s_den[k];
      r_p_h_den[k+1] <= r_p_h_den[k];
    end
  end

  // Valid chain: in_valid seen together with reset is dropped here.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_p_vld    <= '0;
    end else begin
      r_s1_valid <= bus.in_valid;
      r_s2_valid <= r_s1_valid;
      r_p_vld    <= {r_p_vld[CW-1:0], r_s2_valid};
    end
  end

  // --------------------------------------------------------------------------
  // Stage CW+4: hue offset correction and output registers (hold when idle)
  // --------------------------------------------------------------------------
  logic [CW-1:0] w_h_final;

  always_comb begin
    w_h_final = r_p_neg[CW] ? (r_p_off[CW] - r_p_h_q[CW])
                            : (r_p_off[CW] + r_p_h_q[CW]);
  end

  logic          r_out_valid;
  logic [CW-1:0] r_out_h;
  logic [CW-1:0] r_out_s;
  logic [CW-1:0] r_out_v;
  logic [UW-1:0] r_out_user;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_h     <= '0;
      r_out_s     <= '0;
      r_out_v     <= '0;
      r_out_user  <= '0;
    end else begin
      r_out_valid <= r_p_vld[CW];
      if (r_p_vld[CW]) begin
        r_out_h    <= w_h_final;
        r_out_s    <= r_p_s_q[CW];
        r_out_v    <= r_p_v[CW];
        r_out_user <= r_p_user[CW];
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_h     = r_out_h;
  assign bus.out_s     = r_out_s;
  assign bus.out_v     = r_out_v;
  assign bus.out_user  = r_out_user;

endmodule
`default_nettype wire

// File: doc/hsv_convert_pipe.md
# hsv_convert_pipe

Parametrised, fully pipelined RGB-to-HSV converter for the tracking video path, with a valid strobe and a sideband tag. It replaces the fixed 8-bit converter that depends on vendor divider cores. The block accepts one pixel per clock and uses its own CW-stage restoring dividers. Its fixed latency is CW+4 cycles, and every output pixel stays aligned with its tag for the downstream colour-threshold logic.

## Interface

Parameters:
- CW, 8: component width for R, G, B, H, S and V; legal range 6..12.
- UW, 2: sideband tag width (e.g. hsync/vsync); passes through unchanged.

Ports:
- clock  in  1  system clock; all logic is rising-edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  input pixel qualifier.
- in_r, in_g, in_b  in  CW each  input components, unsigned.
- in_user  in  UW  sideband tag, delayed with its pixel.
- out_valid  out  1  output pixel qualifier.
- out_h, out_s, out_v  out  CW each  hue, saturation, value.
- out_user  out  UW  tag for the pixel currently on the outputs.

## Operation

Definitions: MAXV = 2^CW-1.

- Stage 1: register the inputs, in_valid and in_user.
- Stage 2: compute max, min and max_sel.
  - max_sel tie priority is R, then G, then B (R selected when R>=G and R>=B).
- Stage 3 computes the numerators, denominators and hue context:
  - v = max.
  - delta = max-min.
  - Saturation: s_num = delta*MAXV (2CW bits); s_den = max, or 1 when max=0.
  - Hue difference by max_sel: R uses g-b, G uses b-r, B uses r-g.
  - h_neg = the difference is negative.
  - h_num = |diff|*MAXV.
  - h_den = 6*delta, or 6 when delta=0.
  - h_off: 0 for R, floor(MAXV/3) for G, floor(2*MAXV/3) for B. For CW=8 these are 0, 85, 170.
- Stages 4..CW+3 run two parallel pipelined restoring dividers, one quotient bit per stage, MSB first.
  - Stage 4+k resolves quotient bit CW-1-k by comparing the partial remainder against den<<(CW-1-k).
  - Both quotients are guaranteed < 2^CW (s_q <= MAXV, h_q <= floor(MAXV/6)). No overflow handling is required.
- Stage CW+4 registers the outputs:
  - out_h = (h_off + h_q) mod 2^CW when h_neg=0; (h_off - h_q) mod 2^CW when h_neg=1.
  - out_s = s_q.
  - out_v = v.
- Special cases:
  - delta=0 (grey) gives h=0 and s=0.
  - max=0 (black) gives h=0, s=0, v=0.
- Data registers advance every cycle regardless of valid. There is no back-pressure and no stall input.
- out_h, out_s, out_v and out_user load only when the final-stage valid is 1. They hold their last value otherwise.

## Timing

- Latency: a pixel presented with in_valid=1 at edge N appears with out_valid=1 at edge N+CW+4. For CW=8 this is 12 cycles.
- Throughput: one pixel per clock, including back-to-back and arbitrarily gapped streams. Output order equals input order, and gaps are preserved exactly.
- Reset behaviour:
  - While reset=1 at an edge, all valid pipeline bits clear and out_valid, out_h, out_s, out_v and out_user clear to 0.
  - Pixels in flight when reset asserts are discarded; none emerge afterwards.
  - in_valid sampled in the same cycle as reset=1 is ignored.
  - The first out_valid after reset occurs CW+4 cycles after the first accepted in_valid.
- No combinational path runs from inputs to outputs.
- The longest path per stage is one CW+log2(6)+CW-bit compare/subtract.

## Test plan

- CW=8, single pixel (255,0,0) with tag 2: out_valid exactly 12 cycles later, h=0, s=255, v=255, user=2. Pixel (0,255,0) gives h=85, s=255, v=255. Pixel (0,0,255) gives h=170, s=255, v=255.
- (200,100,50) gives h=14, s=191, v=200. (255,0,128) has R max with negative difference: h_q=21, so h=235, s=255, v=255.
- Grey and black: (100,100,100) gives h=0, s=0, v=100. (0,0,0) gives h=0, s=0, v=0.
- Ties: (200,200,50) must take the R branch, giving h=42, s=191, v=200. (50,200,200) must take the G branch, giving h=127, s=191, v=200.
- Streaming: 1000 random pixels with random in_valid gaps and incrementing tags. Every output must match a bit-exact golden model with identical gap pattern and tag order. Assert reset mid-stream: no stale out_valid afterwards, and outputs read 0 until the next new pixel emerges.
- CW=10: (1023,0,0) gives h=0, s=1023, v=1023 at 14 cycles. (0,1023,0) gives h=341.
